display_scanout: RTL and testbench
==================================

Name: display_scanout

Overview:
- Parametrised display output stage: video timing generator, pixel-memory read-address generator and colour expander in one block.
- Produces read coordinates for the frame store (raymarcher / M10K buffer).
- Delays timing by the memory read latency so sync, de and coordinates stay aligned with returned pixel data.
- Expands RGB565 to RGB888 and blanks colour outside the active area; drives the VGA pins or the SDL sim harness.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- CORDW, 10, coordinate width
- SCALE_SHIFT, 0, read coordinate = screen coordinate >> SCALE_SHIFT
- RD_LAT, 2, pixel-memory read latency in cycles (>= 0)
- EXPAND_MODE, 1, 1 = MSB replication, 0 = zero fill

Ports:
- clk_pix  in  1  pixel clock
- rst_pix  in  1  asynchronous active-high reset
- rd_x  out  CORDW  frame-store read x
- rd_y  out  CORDW  frame-store read y
- rd_en  out  1  read request, high in the active area
- px_data  in  16  RGB565 pixel, valid RD_LAT cycles after the matching rd_*
- test_en  in  1  colour-bar select (used only with the optional feature)
- sx  out  CORDW  aligned screen x
- sy  out  CORDW  aligned screen y
- de  out  1  aligned data enable
- hsync  out  1  aligned horizontal sync
- vsync  out  1  aligned vertical sync
- r, g, b  out  8 each  RGB888 colour
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- line_start  out  1  one-cycle pulse with sx=0 on every line

Behaviour:
- Timing constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit in CORDW bits.
- Counters hc and vc:
  - Active area starts at 0.
  - hc increments every cycle and wraps from H_TOTAL-1 to 0.
  - vc increments on hc wrap and wraps from V_TOTAL-1 to 0.
  - Simultaneous h and v wrap gives (0,0).
- Combinational from the counters in cycle t:
  - de_c = hc<H_ACTIVE && vc<V_ACTIVE.
  - hs_c active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_c active for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Active level is SYNC_POL.
- rd_x = hc>>SCALE_SHIFT, rd_y = vc>>SCALE_SHIFT, rd_en = de_c; all driven in cycle t.
- In blanking, rd_x/rd_y carry the shifted counter values and are don't-care to the memory.
- Alignment pipeline:
  - hc, vc, de_c, hs_c, vs_c and frame/line flags pass through RD_LAT register stages.
  - At cycle t+RD_LAT, px_data is combined with the delayed timing.
  - All outputs register on that edge, so they are visible in cycle t+RD_LAT+1.
  - Total latency from counter to pins is RD_LAT+1 cycles.
  - RD_LAT=0 means px_data is sampled in the same cycle as rd_*.
- Expansion:
  - EXPAND_MODE=1: r={R5,R5[4:2]}, g={G6,G6[5:4]}, b={B5,B5[4:2]}.
  - EXPAND_MODE=0: r={R5,3'b0}, g={G6,2'b0}, b={B5,3'b0}.
- Blanking: when the aligned de=0, r=g=b=0 regardless of px_data.
- frame_start = aligned (hc==0 && vc==0); line_start = aligned (hc==0), including blanking lines.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - Counters go to 0.
  - All pipeline stages clear to de=0, syncs inactive (~SYNC_POL), coordinates 0, flags 0.
  - Outputs: sx=sy=0, de=0, hsync=vsync=~SYNC_POL, r=g=b=0, frame_start=line_start=0.
  - rd_x=rd_y=0 and rd_en=1 while held in reset (follow the counters).
  - After release, pixel (0,0) reaches the outputs at the RD_LAT+1th rising edge, with frame_start=1 and line_start=1.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined, with test_en=1: pre-blanking colour is replaced by 8 vertical bars, each H_ACTIVE/8 wide, by aligned sx.
  - Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - px_data is ignored; timing, rd_* and blanking are unchanged.
  - test_en is sampled at the output register; a change mid-line takes effect on the next cycle.
- Not defined: test_en is ignored and no bar logic is generated.

Test Plan:
1. Reset held 5 cycles, released at t0, RD_LAT=2 -> at the 3rd edge after t0: sx=0, sy=0, de=1, frame_start=1, line_start=1; before that, de=0, syncs high, rgb=0.
2. Free run, defaults -> 800 cycles/line, de high for 640, hsync low for 96 cycles starting at sx=656, vsync low on sy=490-491, frame_start period 420000 cycles.
3. px_data=16'hF81F -> replicate: r=FF, g=00, b=FF; zero fill: F8, 00, F8. px_data=16'h07E0 -> g=FF (replicate) / FC (zero fill).
4. px_data=16'hFFFF held through blanking -> r=g=b=0 for aligned sx 640..799 and for all of sy>=480.
5. SCALE_SHIFT=1 -> rd_x=319 at hc=639, rd_y=239 at vc=479, rd_en=0 at hc=640.
6. TEST_PATTERN_EN defined, test_en=1 -> aligned sx=0: FFFFFF; sx=80: FFFF00; sx=639: 000000; sx=700: 000000 with de=0.

Source files
------------

// File: rtl/display_scanout.sv
// display_scanout: video timing generator, frame-store read-address generator
// and RGB565->RGB888 colour expander in one block.
//
// The counters (hc, vc) drive the frame-store read port directly. The timing
// derived from them is delayed by RD_LAT stages so that it lines up with the
// returned pixel. Everything then lands in one output register, which makes
// counter-to-pin latency RD_LAT+1 cycles.
//
// Optional feature: define TEST_PATTERN_EN to build an 8-bar colour test
// pattern, selected at run time by test_en. Without the macro, test_en is
// ignored and no bar logic exists.
//
// Handshake note: there is no flow control. rd_en is a pure request strobe
// (high in the active area). px_data must be valid exactly RD_LAT cycles
// after the matching rd_x/rd_y, with no back-pressure in either direction.

module display_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  parameter int CORDW       = 10,
  parameter int SCALE_SHIFT = 0,
  parameter int RD_LAT      = 2,
  parameter int EXPAND_MODE = 1
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  output logic [CORDW-1:0] rd_x,
  output logic [CORDW-1:0] rd_y,
  output logic             rd_en,
  input  logic [15:0]      px_data,
  input  logic             test_en,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_FIRST = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_LAST  = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_FIRST = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_LAST  = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_ACT = (SYNC_POL != 0);

  // Counters must be able to hold the last position of a line and a frame.
  if ((H_TOTAL - 1) >= (1 << CORDW) || (V_TOTAL - 1) >= (1 << CORDW)) begin : g_bad_cordw
    $error("display_scanout: CORDW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end
  if (RD_LAT < 0) begin : g_bad_lat
    $error("display_scanout: RD_LAT must be >= 0");
  end

  // One bundle of timing information, carried down the alignment pipeline.
  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             de;
    logic             hs;
    logic             vs;
    logic             fs;
    logic             ls;
  } tim_t;

  localparam tim_t TIM_IDLE = '{x: '0, y: '0, de: 1'b0, hs: ~SYNC_ACT,
                                vs: ~SYNC_ACT, fs: 1'b0, ls: 1'b0};

  logic [CORDW-1:0] hc_q, hc_d;
  logic [CORDW-1:0] vc_q, vc_d;
  tim_t             tim_c;
  tim_t             tim_al;

  // Raster position: hc wraps every line, vc advances on each hc wrap.
  always_comb begin
    hc_d = hc_q + CORDW'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) vc_d = '0;
      else                vc_d = vc_q + CORDW'(1);
    end
  end

  // Counter registers; reset parks them on pixel (0,0).
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Undelayed timing decoded from the counters.
  always_comb begin
    tim_c    = TIM_IDLE;
    tim_c.x  = hc_q;
    tim_c.y  = vc_q;
    tim_c.de = (hc_q < H_ACT) && (vc_q < V_ACT);
    tim_c.hs = ((hc_q >= HS_FIRST) && (hc_q <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    tim_c.vs = ((vc_q >= VS_FIRST) && (vc_q <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    tim_c.fs = (hc_q == '0) && (vc_q == '0);
    tim_c.ls = (hc_q == '0);
  end

  // Frame-store request in the counter cycle; blanking addresses are don't-care.
  assign rd_x  = hc_q >> SCALE_SHIFT;
  assign rd_y  = vc_q >> SCALE_SHIFT;
  assign rd_en = tim_c.de;

  if (RD_LAT == 0) begin : g_no_lat
    assign tim_al = tim_c;
  end else begin : g_lat
    tim_t pipe_q [RD_LAT];

    // Delay timing by the memory read latency.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
        for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= TIM_IDLE;
      end else begin
        pipe_q[0] <= tim_c;
        for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign tim_al = pipe_q[RD_LAT-1];
  end

  logic [7:0] r_d, g_d, b_d;

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [CORDW-1:0] bar_idx;
  logic [2:0]       bar_sel;
  logic [23:0]      bar_rgb;

  // Bar colour chosen from the aligned screen x; anything past bar 7 is black.
  always_comb begin
    bar_idx = tim_al.x / CORDW'(BAR_W);
    bar_sel = (bar_idx > CORDW'(7)) ? 3'd7 : bar_idx[2:0];
    case (bar_sel)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
`endif

  // Colour expansion, optional test bars, then blanking outside the active area.
  always_comb begin
    if (EXPAND_MODE != 0) begin
      r_d = {px_data[15:11], px_data[15:13]};
      g_d = {px_data[10:5],  px_data[10:9]};
      b_d = {px_data[4:0],   px_data[4:2]};
    end else begin
      r_d = {px_data[15:11], 3'b000};
      g_d = {px_data[10:5],  2'b00};
      b_d = {px_data[4:0],   3'b000};
    end
`ifdef TEST_PATTERN_EN
    if (test_en) {r_d, g_d, b_d} = bar_rgb;
`endif
    if (!tim_al.de) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  logic [CORDW-1:0] sx_q, sy_q;
  logic             de_q, hs_q, vs_q, fs_q, ls_q;
  logic [7:0]       r_q, g_q, b_q;

  // Output register: aligned timing and colour change together on this edge.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx_q <= '0;
      sy_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~SYNC_ACT;
      vs_q <= ~SYNC_ACT;
      fs_q <= 1'b0;
      ls_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      sx_q <= tim_al.x;
      sy_q <= tim_al.y;
      de_q <= tim_al.de;
      hs_q <= tim_al.hs;
      vs_q <= tim_al.vs;
      fs_q <= tim_al.fs;
      ls_q <= tim_al.ls;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout on a reduced raster (80x14 total, 64x8 active).
// Instance A: RD_LAT=2, SCALE_SHIFT=1, MSB replication, active-low syncs.
// Instance B: RD_LAT=0, SCALE_SHIFT=0, zero fill, active-high syncs.
// The frame store is emulated from a cycle index: a pixel request made in
// cycle c is answered in cycle c+RD_LAT. The expected outputs come from a
// position-based model of the raster.

module tb_display_scanout;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        test_en;
  logic [15:0] px_a, px_b;

  logic [9:0] rd_x_a, rd_y_a, sx_a, sy_a;
  logic       rd_en_a, de_a, hs_a, vs_a, fs_a, ls_a;
  logic [7:0] r_a, g_a, b_a;

  logic [9:0] rd_x_b, rd_y_b, sx_b, sy_b;
  logic       rd_en_b, de_b, hs_b, vs_b, fs_b, ls_b;
  logic [7:0] r_b, g_b, b_b;

  display_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .CORDW(10), .SCALE_SHIFT(1), .RD_LAT(2), .EXPAND_MODE(1)
  ) dut_a (
    .clk_pix(clk), .rst_pix(rst),
    .rd_x(rd_x_a), .rd_y(rd_y_a), .rd_en(rd_en_a),
    .px_data(px_a), .test_en(test_en),
    .sx(sx_a), .sy(sy_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .r(r_a), .g(g_a), .b(b_a),
    .frame_start(fs_a), .line_start(ls_a)
  );

  display_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1), .CORDW(10), .SCALE_SHIFT(0), .RD_LAT(0), .EXPAND_MODE(0)
  ) dut_b (
    .clk_pix(clk), .rst_pix(rst),
    .rd_x(rd_x_b), .rd_y(rd_y_b), .rd_en(rd_en_b),
    .px_data(px_b), .test_en(test_en),
    .sx(sx_b), .sy(sy_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .r(r_b), .g(g_b), .b(b_b),
    .frame_start(fs_b), .line_start(ls_b)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Frame-store contents: four directed RGB565 values laid out diagonally.
  function automatic logic [15:0] mem_rd(input int x, input int y);
    case ((x + y) % 4)
      0:       return 16'hF81F;
      1:       return 16'h07E0;
      2:       return 16'hFFFF;
      default: return 16'h1234;
    endcase
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p, input bit rep);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    r8 = r5 * 8 + (rep ? r5 / 4 : 0);
    g8 = g6 * 4 + (rep ? g6 / 16 : 0);
    b8 = b5 * 8 + (rep ? b5 / 4 : 0);
    return {8'(r8), 8'(g8), 8'(b8)};
  endfunction

  function automatic logic [23:0] bar(input int x);
    int idx;
    idx = x / (HA / 8);
    if (idx > 7) idx = 7;
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Read port in cycle c (c cycles after reset release): {rd_x, rd_y, rd_en}.
  function automatic logic [20:0] model_rd(input int c, input int shift);
    int p, x, y;
    p = c % FT;
    x = p % HT;
    y = p / HT;
    return {10'(x >> shift), 10'(y >> shift), (x < HA) && (y < VA)};
  endfunction

  // Pin state after c edges: {sx, sy, de, hsync, vsync, frame_start, line_start, rgb}.
  function automatic logic [48:0] model_out(input int c, input int lat, input int shift,
                                            input bit rep, input bit pol, input bit te);
    int a, p, x, y;
    logic de_m, hs_m, vs_m;
    logic [23:0] rgb;
    a = c - 1 - lat;
    if (a < 0) return {20'd0, 1'b0, ~pol, ~pol, 2'b00, 24'd0};
    p = a % FT;
    x = p % HT;
    y = p / HT;
    de_m = (x < HA) && (y < VA);
    hs_m = (x >= HA + HF && x < HA + HF + HS) ? pol : ~pol;
    vs_m = (y >= VA + VF && y < VA + VF + VS) ? pol : ~pol;
    rgb  = expand(mem_rd(x >> shift, y >> shift), rep);
`ifdef TEST_PATTERN_EN
    if (te) rgb = bar(x);
`else
    if (te) rgb = rgb;
`endif
    if (!de_m) rgb = 24'd0;
    return {10'(x), 10'(y), de_m, hs_m, vs_m, (x == 0 && y == 0), (x == 0), rgb};
  endfunction

  // Memory answer presented in cycle c for a latency-lat, shift-scaled reader.
  function automatic logic [15:0] px_for(input int c, input int lat, input int shift);
    int p;
    if (c - lat < 0) return 16'hFFFF;
    p = (c - lat) % FT;
    return mem_rd((p % HT) >> shift, (p / HT) >> shift);
  endfunction

  // ---------------- driver / compare ----------------
  bit te_last = 1'b0;

  task automatic check_reset(input string tag);
    chk({tag, "_A_rd"},  {rd_x_a, rd_y_a, rd_en_a}, {10'd0, 10'd0, 1'b1});
    chk({tag, "_B_rd"},  {rd_x_b, rd_y_b, rd_en_b}, {10'd0, 10'd0, 1'b1});
    chk({tag, "_A_out"}, {sx_a, sy_a, de_a, hs_a, vs_a, fs_a, ls_a, r_a, g_a, b_a},
        {20'd0, 1'b0, 1'b1, 1'b1, 2'b00, 24'd0});
    chk({tag, "_B_out"}, {sx_b, sy_b, de_b, hs_b, vs_b, fs_b, ls_b, r_b, g_b, b_b},
        {20'd0, 1'b0, 1'b0, 1'b0, 2'b00, 24'd0});
  endtask

  // Called at the falling edge of cycle 0 (just after reset release); checks
  // every cycle and returns at the falling edge of cycle ncyc.
  task automatic run_seg(input int seg, input int ncyc, input int te_on);
    int last_fs = -1;
    bit te_used;
    for (int c = 0; c < ncyc; c++) begin
      te_used = te_last;
      test_en = (c >= te_on);
      te_last = test_en;
      px_a = px_for(c, 2, 1);
      px_b = px_for(c, 0, 0);

      chk("A_rd", {rd_x_a, rd_y_a, rd_en_a}, model_rd(c, 1));
      chk("B_rd", {rd_x_b, rd_y_b, rd_en_b}, model_rd(c, 0));
      chk("A_out", {sx_a, sy_a, de_a, hs_a, vs_a, fs_a, ls_a, r_a, g_a, b_a},
          model_out(c, 2, 1, 1'b1, 1'b0, te_used));
      chk("B_out", {sx_b, sy_b, de_b, hs_b, vs_b, fs_b, ls_b, r_b, g_b, b_b},
          model_out(c, 0, 0, 1'b0, 1'b1, te_used));

      if (fs_a) begin
        if (last_fs >= 0) chk("A_fs_period", c - last_fs, FT);
        last_fs = c;
      end

      // Hand-computed pins on the first segment (test_en low there).
      if (seg == 1) begin
        if (c == 2)   chk("A_pre_de", de_a, 1'b0);
        if (c == 3)   chk("A_px00", {sx_a, sy_a, de_a, hs_a, vs_a, fs_a, ls_a, r_a, g_a, b_a},
                          {20'd0, 5'b11111, 24'hFF00FF});
        if (c == 1)   chk("B_px00", {sx_b, sy_b, de_b, hs_b, vs_b, fs_b, ls_b, r_b, g_b, b_b},
                          {20'd0, 5'b10011, 24'hF800F8});
        if (c == 5)   chk("A_rep_07E0", {r_a, g_a, b_a}, 24'h00FF00);
        if (c == 7)   chk("A_rep_FFFF", {r_a, g_a, b_a}, 24'hFFFFFF);
        if (c == 9)   chk("A_rep_1234", {r_a, g_a, b_a}, 24'h1045A5);
        if (c == 2)   chk("B_zf_07E0", {r_b, g_b, b_b}, 24'h00FC00);
        if (c == 3)   chk("B_zf_FFFF", {r_b, g_b, b_b}, 24'hF8FCF8);
        if (c == 4)   chk("B_zf_1234", {r_b, g_b, b_b}, 24'h1044A0);
        if (c == 67)  chk("A_blank_sx64", {de_a, r_a, g_a, b_a}, 25'd0);
        if (c == 70)  chk("A_hs_sx67", {sx_a, hs_a}, {10'd67, 1'b1});
        if (c == 71)  chk("A_hs_sx68", {sx_a, hs_a}, {10'd68, 1'b0});
        if (c == 78)  chk("A_hs_sx75", {sx_a, hs_a}, {10'd75, 1'b0});
        if (c == 79)  chk("A_hs_sx76", {sx_a, hs_a}, {10'd76, 1'b1});
        if (c == 68)  chk("B_hs_sx67", {sx_b, hs_b}, {10'd67, 1'b0});
        if (c == 69)  chk("B_hs_sx68", {sx_b, hs_b}, {10'd68, 1'b1});
        if (c == 63)  chk("A_rdx_639", {rd_x_a, rd_en_a}, {10'd31, 1'b1});
        if (c == 64)  chk("A_rden_640", {rd_x_a, rd_en_a}, {10'd32, 1'b0});
        if (c == 560) chk("A_rdy_479", rd_y_a, 10'd3);
        if (c == 802) chk("A_vs_sy9", {sy_a, vs_a}, {10'd9, 1'b1});
        if (c == 803) chk("A_vs_sy10", {sy_a, vs_a}, {10'd10, 1'b0});
        if (c == 883) chk("A_vs_sy11", {sy_a, vs_a, ls_a}, {10'd11, 1'b0, 1'b1});
        if (c == 963) chk("A_vs_sy12", {sy_a, vs_a}, {10'd12, 1'b1});
        if (c == 1123) chk("A_fs_frame2", {sx_a, sy_a, fs_a, ls_a}, {20'd0, 2'b11});
      end

      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus + report ----------------
  initial begin
    rst     = 1'b1;
    test_en = 1'b0;
    px_a    = 16'hFFFF;
    px_b    = 16'hFFFF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b0;
    // Two full frames plus a bit; test_en rises mid-line in frame 2.
    run_seg(1, 2400, 1500);

    // Asynchronous reset in the middle of a frame.
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    repeat (3) begin
      @(negedge clk);
      check_reset("rst_mid");
    end
    rst = 1'b0;
    run_seg(2, 400, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
